// File: rtl/jacaranda_pkg.sv
// Shared definitions for the instruction-memory boot loader and the CPU it feeds.
// Holds the loader state encoding, frame constants and memory interface widths.
package jacaranda_pkg;

    localparam int INSTR_W = 8;
    localparam int ADDR_W  = 8;

    localparam logic [INSTR_W-1:0] DEF_SYNC_BYTE      = 8'hA5;
    localparam logic [INSTR_W-1:0] DEF_HOLD_INSTR     = 8'h00;
    localparam int unsigned        DEF_TIMEOUT_CYCLES = 50000;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC,
        ST_LEN,
        ST_DATA,
        ST_SUM,
        ST_RUN
    } loader_state_t;

    // A length byte of zero encodes a full 256-byte image.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Saturating inter-byte timer: counts enabled cycles since the last clear and
// flags terminal count. A LIMIT of zero never reaches terminal count.
module loader_timeout #(
    parameter int unsigned LIMIT = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int unsigned    CW      = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  C_LIMIT = CW'(LIMIT);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (LIMIT != 0) && (r_count == C_LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Boot/reload controller: receives a framed image (sync, length, data, checksum)
// over a byte stream, writes it into instruction memory, then hands the port to the CPU.
module imem_loader
    import jacaranda_pkg::*;
#(
    parameter logic [INSTR_W-1:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [INSTR_W-1:0] HOLD_INSTR     = DEF_HOLD_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic [INSTR_W-1:0] cpu_instr,
    output logic               cpu_hold,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               mem_we,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               load_done,
    output logic               load_err,
    output logic [8:0]         bytes_loaded
);

    loader_state_t      r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  r_waddr;
    logic [INSTR_W-1:0] r_wdata;
    logic               r_we;
    logic [INSTR_W-1:0] r_acc;
    logic [8:0]         r_remain;
    logic [8:0]         r_len;
    logic [8:0]         r_bytes_loaded;
    logic               r_done;
    logic               r_err;
    logic               r_hold;

    logic w_xfer;
    logic w_in_frame;
    logic w_timeout;

    // Every state accepts a byte, so the stream can run at one byte per clock.
    assign rx_ready   = 1'b1;
    assign w_xfer     = rx_valid & rx_ready;
    assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_SUM);

    loader_timeout #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_xfer || !w_in_frame),
        .i_enable (w_in_frame),
        .o_tc     (w_timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_WAIT_SYNC;
            r_ptr          <= '0;
            r_waddr        <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_acc          <= '0;
            r_remain       <= '0;
            r_len          <= '0;
            r_bytes_loaded <= '0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_hold         <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;

            case (r_state)
                ST_WAIT_SYNC: begin
                    if (w_xfer && (rx_data == SYNC_BYTE)) begin
                        r_state <= ST_LEN;
                        r_err   <= 1'b0;
                        r_ptr   <= '0;
                        r_acc   <= '0;
                    end
                end

                ST_LEN: begin
                    if (w_xfer) begin
                        r_remain <= frame_len(rx_data);
                        r_len    <= frame_len(rx_data);
                        r_state  <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    // Sync bytes here are payload; there is no mid-frame resync.
                    if (w_xfer) begin
                        r_we     <= 1'b1;
                        r_waddr  <= r_ptr;
                        r_wdata  <= rx_data;
                        r_ptr    <= r_ptr + 8'd1;
                        r_acc    <= r_acc + rx_data;
                        r_remain <= r_remain - 9'd1;
                        if (r_remain == 9'd1) begin
                            r_state <= ST_SUM;
                        end
                    end
                end

                ST_SUM: begin
                    if (w_xfer) begin
                        if (rx_data == r_acc) begin
                            r_state        <= ST_RUN;
                            r_done         <= 1'b1;
                            r_hold         <= 1'b0;
                            r_bytes_loaded <= r_len;
                        end else begin
                            r_state <= ST_WAIT_SYNC;
                            r_err   <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_xfer && (rx_data == SYNC_BYTE)) begin
                        r_state <= ST_LEN;
                        r_hold  <= 1'b1;
                        r_ptr   <= '0;
                        r_acc   <= '0;
                    end
                end

                default: begin
                    r_state <= ST_WAIT_SYNC;
                    r_hold  <= 1'b1;
                end
            endcase

            // An accepted byte always beats a timeout that fires in the same cycle.
            if (w_in_frame && !w_xfer && w_timeout) begin
                r_state <= ST_WAIT_SYNC;
                r_err   <= 1'b1;
            end
        end
    end

    // NOTE: combinational mux assigns defaults first so no path can infer a latch.
    always_comb begin
        mem_addr  = r_ptr;
        cpu_instr = HOLD_INSTR;
        if (!r_hold) begin
            mem_addr  = cpu_addr;
            cpu_instr = mem_rdata;
        end else if (r_we) begin
            mem_addr = r_waddr;
        end
    end

    assign mem_we       = r_we;
    assign mem_wdata    = r_wdata;
    assign cpu_hold     = r_hold;
    assign load_done    = r_done;
    assign load_err     = r_err;
    assign bytes_loaded = r_bytes_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum errors, 256-byte wrap,
// inter-byte timeout, CPU pass-through and asynchronous reset mid-frame.
module tb_imem_loader;

    localparam int unsigned T_OUT = 20;

    logic       clock;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_instr;
    logic       cpu_hold;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       load_done;
    logic       load_err;
    logic [8:0] bytes_loaded;

    logic [7:0] mem [256];
    int         writes;
    int         done_count;
    int         checks;
    int         failures;

    imem_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (T_OUT),
        .HOLD_INSTR     (8'h00)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .cpu_addr     (cpu_addr),
        .cpu_instr    (cpu_instr),
        .cpu_hold     (cpu_hold),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .load_done    (load_done),
        .load_err     (load_err),
        .bytes_loaded (bytes_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural instruction memory with combinational read.
    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr] <= mem_wdata;
            writes        <= writes + 1;
        end
        if (load_done === 1'b1) begin
            done_count <= done_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        logic [7:0] exp_a [3];
        exp_a = '{8'hC0, 8'hD7, 8'h03};

        checks     = 0;
        failures   = 0;
        writes     = 0;
        done_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_addr = 8'h00;
        #3;
        check("rst_hold",      cpu_hold,     1);
        check("rst_ready",     rx_ready,     1);
        check("rst_we",        mem_we,       0);
        check("rst_wdata",     mem_wdata,    0);
        check("rst_done",      load_done,    0);
        check("rst_err",       load_err,     0);
        check("rst_bytes",     bytes_loaded, 0);
        check("rst_instr",     cpu_instr,    8'h00);
        check("rst_addr",      mem_addr,     8'h00);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(1);

        // Garbage before sync is discarded.
        w0 = writes;
        send(8'h11);
        send(8'h22);
        idle(1);
        check("garbage_writes", writes - w0, 0);
        check("garbage_hold",   cpu_hold,    1);

        // Good frame A5 03 C0 D7 03 9A.
        d0 = done_count;
        send(8'hA5); send(8'h03); send(8'hC0); send(8'hD7); send(8'h03);
        check("f1_last_we",    mem_we,    1);
        check("f1_last_addr",  mem_addr,  8'h02);
        check("f1_last_wdata", mem_wdata, 8'h03);
        check("f1_hold_pre",   cpu_hold,  1);
        send(8'h9A);
        check("f1_done",  load_done,    1);
        check("f1_hold",  cpu_hold,     0);
        check("f1_bytes", bytes_loaded, 3);
        check("f1_err",   load_err,     0);
        idle(3);
        check("f1_done_once", done_count - d0, 1);
        check("f1_mem0", mem[0], 8'hC0);
        check("f1_mem1", mem[1], 8'hD7);
        check("f1_mem2", mem[2], 8'h03);

        // CPU fetch pass-through in RUN.
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 8'(i);
            #1;
            check("run_instr", cpu_instr, exp_a[i]);
            check("run_addr",  mem_addr,  i);
        end
        cpu_addr = 8'h00;

        // Sync in RUN re-holds the CPU on the next cycle.
        send(8'hA5);
        check("resync_hold",  cpu_hold,  1);
        check("resync_instr", cpu_instr, 8'h00);

        // Bad checksum 9B.
        send(8'h03); send(8'hC0); send(8'hD7); send(8'h03); send(8'h9B);
        check("bad_err",  load_err,  1);
        check("bad_hold", cpu_hold,  1);
        check("bad_done", load_done, 0);
        w0 = writes;
        send(8'h03);
        idle(1);
        check("bad_wait_sync", writes - w0, 0);
        check("bad_hold2",     cpu_hold,    1);

        // Following good frame clears the error and releases the CPU.
        send(8'hA5);
        check("good_err_clr", load_err, 0);
        send(8'h03); send(8'hC0); send(8'hD7); send(8'h03); send(8'h9A);
        check("good_hold", cpu_hold, 0);
        check("good_err",  load_err, 0);

        // Length 00: 256 bytes of 0x01, checksum 00.
        send(8'hA5);
        send(8'h00);
        w0 = writes;
        for (int i = 0; i < 255; i++) send(8'h01);
        check("f256_hold_mid", cpu_hold, 1);
        send(8'h01);
        check("f256_last_we",   mem_we,   1);
        check("f256_last_addr", mem_addr, 8'hFF);
        send(8'h00);
        check("f256_done",  load_done,    1);
        check("f256_hold",  cpu_hold,     0);
        check("f256_bytes", bytes_loaded, 9'h100);
        idle(1);
        check("f256_writes", writes - w0, 256);
        check("f256_mem0",   mem[0],   8'h01);
        check("f256_memff",  mem[255], 8'h01);

        // Stall after the second data byte.
        w0 = writes;
        send(8'hA5); send(8'h03); send(8'hC0); send(8'hD7);
        idle(int'(T_OUT) - 1);
        check("to_not_yet", load_err, 0);
        idle(3);
        check("to_err",  load_err, 1);
        check("to_hold", cpu_hold, 1);
        send(8'h03);
        send(8'h9A);
        idle(2);
        check("to_writes", writes - w0, 2);
        check("to_mem0",   mem[0], 8'hC0);
        check("to_mem2",   mem[2], 8'h01);
        check("to_err2",   load_err, 1);

        // Asynchronous reset in the middle of DATA.
        send(8'hA5); send(8'h02); send(8'h11);
        check("mid_we_pre", mem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we",    mem_we,       0);
        check("mid_rst_hold",  cpu_hold,     1);
        check("mid_rst_bytes", bytes_loaded, 0);
        check("mid_rst_wdata", mem_wdata,    0);
        check("mid_rst_done",  load_done,    0);
        check("mid_rst_ready", rx_ready,     1);
        @(negedge clock);
        reset = 1'b0;
        idle(1);
        send(8'h7E);
        check("post_rst_hold", cpu_hold, 1);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7E);
        check("post_rst_done",  load_done,    1);
        check("post_rst_hold2", cpu_hold,     0);
        check("post_rst_bytes", bytes_loaded, 1);
        idle(1);
        check("post_rst_mem0", mem[0], 8'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot/reload controller that owns the single port of a writable 8-bit instruction memory.
- Holds the CPU, receives a framed program image over a byte stream (UART RX side), writes it from address 0, verifies a checksum, then releases the CPU.
- After release, the memory port passes through to CPU fetch.
- A new sync byte at any time re-enters load mode.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clocks during an open frame; 0 disables it.
- HOLD_INSTR, 8'h00, instruction presented to the CPU while held.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte; transfer = rx_valid & rx_ready at the clock edge.
- cpu_addr  in  8  CPU program counter.
- cpu_instr  out  8  instruction to the CPU.
- cpu_hold  out  1  CPU stall/reset request.
- mem_addr  out  8  instruction memory address.
- mem_wdata  out  8  instruction memory write data.
- mem_we  out  1  instruction memory write enable.
- mem_rdata  in  8  instruction memory read data (combinational read).
- load_done  out  1  one-cycle pulse when a frame completes successfully.
- load_err  out  1  sticky error flag.
- bytes_loaded  out  9  length of the last accepted frame, 1..256.

Behaviour:
- Reset (async, all outputs):
  - state WAIT_SYNC; cpu_hold=1; rx_ready=1; mem_we=0; mem_wdata=0.
  - load_done=0; load_err=0; bytes_loaded=0; write pointer=0; checksum accumulator=0; timeout counter=0.
- States: WAIT_SYNC, LEN, DATA, SUM, RUN. rx_ready=1 in every state; one byte per cycle is sustainable.
- WAIT_SYNC:
  - Byte == SYNC_BYTE → LEN; load_err cleared; pointer=0; accumulator=0.
  - Any other byte is discarded.
- LEN:
  - Byte L is taken as the length; L=0 means 256. Store the remaining count → DATA.
- DATA:
  - Each accepted byte b: the next cycle drives mem_we=1, mem_addr=pointer, mem_wdata=b (one-cycle write latency).
  - Then pointer += 1 (8-bit wrap; 256 bytes ends at 0xFF); accumulator += b mod 256.
  - After the L-th byte → SUM.
- SUM:
  - Byte == accumulator → RUN; load_done pulses the following cycle; bytes_loaded=L.
  - Mismatch → WAIT_SYNC with load_err=1. Memory contents written so far remain; cpu_hold stays 1.
- RUN:
  - cpu_hold=0.
  - Byte == SYNC_BYTE → LEN and cpu_hold=1 in the cycle after acceptance. Other bytes are discarded.
- cpu_hold:
  - Deasserts the cycle after the SUM byte is accepted, coincident with load_done.
  - Asserted in all states except RUN.
- Memory mux:
  - While cpu_hold=1: mem_addr = write pointer (or the registered write address when mem_we=1); cpu_instr = HOLD_INSTR.
  - In RUN: mem_addr = cpu_addr; cpu_instr = mem_rdata; mem_we=0.
- Timeout:
  - Counter clears on every accepted byte and is idle in WAIT_SYNC/RUN.
  - Reaching TIMEOUT_CYCLES in LEN/DATA/SUM → WAIT_SYNC, load_err=1.
- Simultaneous events:
  - A byte accepted in the cycle the timeout fires wins; the counter clears and the state advances normally.
  - A sync byte inside DATA is treated as data. There is no resync mid-frame.
- Reset mid-frame: aborts; the CPU stays held until a full valid frame arrives.

Decomposition:
- Shared package jacaranda_pkg holds:
  - the loader state enum;
  - SYNC_BYTE and HOLD_INSTR default constants;
  - the 8-bit instr/addr width constants shared with the CPU.
- One sub-module, loader_timeout: a saturating counter with clear/enable and a terminal-count output.

Test Plan:
- Frame A5 03 C0 D7 03 9A → memory[0..2]=C0,D7,03; load_done pulses once; cpu_hold falls the same cycle; bytes_loaded=3; load_err=0.
- Same frame with checksum 9B → load_err=1; cpu_hold stays 1; state returns to WAIT_SYNC. A following good frame clears load_err and releases the CPU.
- Length 00 with 256 bytes of 0x01, checksum 00 → writes at 0x00..0xFF; pointer wraps; bytes_loaded=256.
- Garbage bytes 11 22 before A5 are ignored. Stall TIMEOUT_CYCLES after the second data byte → load_err=1 and WAIT_SYNC; no further writes.
- In RUN, sweep cpu_addr 0..2 → cpu_instr matches memory. Send A5 → cpu_hold=1 and cpu_instr=HOLD_INSTR next cycle.
- Assert reset mid-DATA → all outputs return to reset values immediately (asynchronous); mem_we=0.
